// File: rtl/lapido_pkg.sv
// Shared core_lapido constants: register file geometry and writeback requester indices.
package lapido_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 16;

  localparam int unsigned WB_ALU  = 0;
  localparam int unsigned WB_LOAD = 1;
  localparam int unsigned WB_SPEC = 2;

  // One register file write as presented by a writeback requester.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_write_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past each winner.
module rr_arbiter #(
  parameter  int unsigned NREQ = 3,
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  logic [PW-1:0] ptr;
  logic          found;
  int unsigned   idx;

  // First requester at or after ptr wins; nothing is granted in reset or when disabled.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (enable && !rst) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(ptr) + k) % NREQ;
        if (!found && req[PW'(idx)]) begin
          found            = 1'b1;
          gnt[PW'(idx)]    = 1'b1;
          gnt_idx          = PW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NREQ writeback requesters.
// Optional feature: REGFILE_WB_ZERO_REG_EN makes register 0 read-only zero.
module regfile_wb_arbiter
  import lapido_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned DW    = DATA_W,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned NREGS = NUM_REGS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_en,
  output logic [AW-1:0]      rf_rd,
  output logic [DW-1:0]      rf_data,
  output logic               err_addr,
  output logic [1:0]         err_src
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;
  logic            xfer;
  logic            addr_ok;
  logic            zero_hit;
  logic            do_write;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .enable  (!stall),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;

  // Select the granted requester's destination and data.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_rd   = req_rd[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  assign xfer    = |gnt;
  assign addr_ok = 32'(sel_rd) < NREGS;

`ifdef REGFILE_WB_ZERO_REG_EN
  assign zero_hit = (sel_rd == '0);
`else
  assign zero_hit = 1'b0;
`endif

  assign do_write = xfer && addr_ok && !zero_hit;

  // Output stage: async reset discards any write not yet presented to the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_en    <= 1'b0;
      rf_rd    <= '0;
      rf_data  <= '0;
      err_addr <= 1'b0;
      err_src  <= '0;
    end else begin
      rf_en    <= do_write;
      err_addr <= xfer && !addr_ok;
      if (do_write) begin
        rf_rd   <= sel_rd;
        rf_data <= sel_data;
      end
      if (xfer && !addr_ok) begin
        err_src <= 2'(gnt_idx);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then random traffic against a queue-free reference model.
module tb_regfile_wb_arbiter;

  localparam int NREQ  = 3;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREGS = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                stall;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_rd;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                rf_en;
  logic [AW-1:0]       rf_rd;
  logic [DW-1:0]       rf_data;
  logic                err_addr;
  logic [1:0]          err_src;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_en     (rf_en),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .err_addr  (err_addr),
    .err_src   (err_src)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Requester-side view
  bit          v   [NREQ];
  int          rd  [NREQ];
  logic [31:0] dat [NREQ];

  // Reference model state
  int          m_ptr;
  bit          m_en;
  int          m_rd;
  logic [31:0] m_data;
  bit          m_err;
  int          m_src;

  logic [NREQ-1:0] last_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = v[i];
      req_rd[i*AW +: AW]    = AW'(rd[i]);
      req_data[i*DW +: DW]  = dat[i];
    end
  endtask

  function automatic int model_winner();
    if (rst || stall) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_en = 0; m_rd = 0; m_data = '0; m_err = 0; m_src = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rf_en"},    64'(rf_en),    64'(m_en));
    chk({tag, ".rf_rd"},    64'(rf_rd),    64'(m_rd));
    chk({tag, ".rf_data"},  64'(rf_data),  64'(m_data));
    chk({tag, ".err_addr"}, 64'(err_addr), 64'(m_err));
    chk({tag, ".err_src"},  64'(err_src),  64'(m_src));
  endtask

  // One clock: check at negedge, advance model at posedge, leave time at posedge+1.
  task automatic cycle(input string tag);
    int w;
    bit zero;
    logic [NREQ-1:0] eg;
    @(negedge clk);
    w  = model_winner();
    eg = (w < 0) ? '0 : NREQ'(1 << w);
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(eg));
    check_outputs(tag);
    last_gnt = eg;
    @(posedge clk);
    if (w >= 0) begin
`ifdef REGFILE_WB_ZERO_REG_EN
      zero = (rd[w] == 0);
`else
      zero = 0;
`endif
      m_ptr = (w + 1) % NREQ;
      m_en  = (rd[w] < NREGS) && !zero;
      m_err = (rd[w] >= NREGS);
      if (m_en) begin m_rd = rd[w]; m_data = dat[w]; end
      if (m_err) m_src = w;
    end else begin
      m_en  = 0;
      m_err = 0;
    end
    #1;
  endtask

  task automatic release_granted();
    for (int i = 0; i < NREQ; i++) if (last_gnt[i]) v[i] = 0;
    drive();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin v[i] = 0; rd[i] = 0; dat[i] = '0; end
    drive();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("reset.req_ready", 64'(req_ready), 64'(0));
    check_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    req_valid = '0; req_rd = '0; req_data = '0;
    last_gnt = '0;
    for (int i = 0; i < NREQ; i++) begin v[i] = 0; rd[i] = 0; dat[i] = '0; end
    drive();
    apply_reset();

    // Single request
    v[0] = 1; rd[0] = 5; dat[0] = 32'hDEADBEEF; drive();
    cycle("single.c0");
    release_granted();
    cycle("single.c1");
    chk("single.rf_rd_const", 64'(rf_rd), 64'd5);
    cycle("single.c2");

    // Fairness from reset: 0,1,2,0,1,2
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin v[i] = 1; rd[i] = i + 1; dat[i] = 32'h1000 + i; end
    drive();
    for (int n = 0; n < 7; n++) cycle($sformatf("fair.%0d", n));
    clear_reqs();
    cycle("fair.drain");

    // Illegal destination from requester 1, then a legal one
    v[1] = 1; rd[1] = 20; dat[1] = 32'hBAD0BAD0; drive();
    cycle("illegal.grant");
    release_granted();
    v[2] = 1; rd[2] = 4; dat[2] = 32'h44444444; drive();
    cycle("illegal.err");
    chk("illegal.err_src_const", 64'(err_src), 64'd1);
    release_granted();
    cycle("illegal.legal_write");
    cycle("illegal.idle");

    // Stall after one grant: that write still lands, nothing else moves
    for (int i = 0; i < NREQ; i++) begin v[i] = 1; rd[i] = 8 + i; dat[i] = 32'hA000 + i; end
    drive();
    cycle("stall.pre");
    release_granted();
    v[last_gnt == 3'b001 ? 0 : (last_gnt == 3'b010 ? 1 : 2)] = 1; drive();
    stall = 1'b1;
    for (int n = 0; n < 3; n++) cycle($sformatf("stall.%0d", n));
    stall = 1'b0;
    for (int n = 0; n < 4; n++) cycle($sformatf("stall.post%0d", n));
    clear_reqs();
    cycle("stall.drain");

    // Reset while a write of rd=7 is on the port
    v[1] = 1; rd[1] = 7; dat[1] = 32'h77777777; drive();
    cycle("midrst.grant");
    release_granted();
    chk("midrst.rf_en_before", 64'(rf_en), 64'd1);
    v[0] = 1; v[2] = 1; rd[0] = 3; rd[2] = 6; drive();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst.rf_en_async", 64'(rf_en), 64'd0);
    chk("midrst.req_ready", 64'(req_ready), 64'd0);
    check_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    cycle("midrst.first");
    chk("midrst.first_is_0", 64'(last_gnt), 64'd1);
    clear_reqs();
    cycle("midrst.drain");

    // Zero register
    v[2] = 1; rd[2] = 0; dat[2] = 32'h1; drive();
    cycle("zero.grant");
    release_granted();
    cycle("zero.result");
    cycle("zero.idle");

    // Random traffic: requesters hold until granted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && ($urandom_range(0, 1) == 1)) begin
          v[i] = 1; rd[i] = $urandom_range(0, 23); dat[i] = $urandom();
        end
      end
      stall = ($urandom_range(0, 4) == 0);
      drive();
      cycle($sformatf("rand.%0d", n));
      release_granted();
    end
    stall = 1'b0;
    clear_reqs();
    cycle("rand.drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the core_lapido register file. The register file has a single write port (en/rd/data); this block shares it between NREQ writeback requesters (ALU, load unit, move-from-special unit) using round-robin arbitration with a valid/ready handshake. The granted write is registered and driven onto the register file one cycle later. Illegal destination addresses are filtered out and reported.

## Interface
- NREQ, 3, number of writeback requesters
- DW, 32, data width
- AW, 5, destination address width
- NREGS, 16, implemented registers; legal rd is 0..NREGS-1

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  pipeline freeze; blocks all grants while high
- req_valid  in  NREQ  requester i has a write pending
- req_rd  in  NREQ*AW  destination of requester i, slice [i*AW +: AW]
- req_data  in  NREQ*DW  write data of requester i, slice [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; a transfer occurs on valid&ready
- rf_en  out  1  register file write enable
- rf_rd  out  AW  register file write address
- rf_data  out  DW  register file write data
- err_addr  out  1  one-cycle pulse: a transfer carried rd >= NREGS
- err_src  out  2  index of the requester that caused the last err_addr

## Operation
- Round-robin pointer ptr (0..NREQ-1). The winner is the first i with req_valid[i]=1, searching ptr, ptr+1, … modulo NREQ.
- req_ready is combinational from req_valid, ptr and stall. It is one-hot or zero. It is never asserted for a requester with valid=0. It is all-zero while stall=1 or while rst=1.
- On a transfer from requester w, ptr becomes (w+1) mod NREQ at the clock edge. With no transfer, ptr holds.
- A requester keeps valid, rd and data stable until it is granted. The arbiter does not check this.
- A transfer with rd < NREGS: rf_en=1, rf_rd=rd, rf_data=data in the next cycle.
- A transfer with rd >= NREGS: the transfer is accepted (the requester is released), rf_en stays 0, err_addr pulses in the next cycle, and err_src is set to w and holds until the next error.
- With no transfer, the next cycle has rf_en=0. rf_rd and rf_data hold their last values.
- At most one write per cycle. Throughput is 1 write per cycle when any request is valid and stall=0.

## Timing
- Grant to register file write: latency 1 cycle. The transfer happens at edge N and rf_en is high during cycle N+1.
- stall is sampled combinationally. The output stage for a transfer already registered still completes in the next cycle, even if stall has risen.
- Reset values: rf_en=0, rf_rd=0, rf_data=0, err_addr=0, err_src=0, ptr=0, req_ready=0.
- Reset mid-operation: a registered but not yet visible write is discarded, so rf_en=0 immediately and asynchronously. Requesters must re-present their writes.
- Simultaneous requests: with all valid and ptr=0, the grant order is 0,1,2,0,… The worst-case wait for any requester is NREQ-1 cycles with stall=0.
- The wrap-around from ptr=NREQ-1 goes to 0.

## Configuration
- Macro: REGFILE_WB_ZERO_REG_EN.
- Defined: register 0 is read-only zero. A legal transfer with rd=0 completes the handshake but produces rf_en=0 and no err_addr.
- Undefined: rd=0 is an ordinary legal destination and is written.

## Structure
- Shared package lapido_pkg holds:
  - constants REG_AW=5, DATA_W=32, NUM_REGS=16;
  - the requester index constants WB_ALU=0, WB_LOAD=1, WB_SPEC=2.
- Sub-module rr_arbiter: a parameterised NREQ round-robin arbiter holding ptr, with inputs req, enable, rst and output one-hot gnt. The top level adds the mux, address check and output register.

## Test plan
- Single request: req_valid=3'b001, rd=5, data=32'hDEADBEEF. Expect ready[0] in cycle 0, then rf_en=1, rf_rd=5, rf_data=DEADBEEF in cycle 1, then rf_en=0.
- Fairness: all three requesters valid continuously from reset with distinct rd 1/2/3. Expect grants 0,1,2,0,1,2 and rf_rd sequence 1,2,3,1,2,3 each one cycle later.
- Illegal address: requester 1 has rd=20. Expect it to be granted, rf_en=0, err_addr pulsed for one cycle, err_src=1. A following request with rd=4 writes normally.
- Stall: all requesters valid and stall=1 for 3 cycles. Expect req_ready=0 and rf_en=0 throughout, and ptr unchanged. The grant taken just before stall still writes in the next cycle.
- Reset mid-write: assert rst in the cycle after a grant of rd=7. Expect rf_en to drop to 0 immediately and all outputs to reset. After release, the first grant goes to requester 0.
- Zero register: rd=0, data=1. With REGFILE_WB_ZERO_REG_EN defined, expect the handshake to complete with rf_en=0. Undefined, expect rf_en=1 and rf_rd=0.
